// File: rtl/rv_pkg.sv
// Shared encodings for the fetch stage and program counter.
// Holds the halt/hold opcode values and the fetch FSM state type.
package rv_pkg;

  localparam logic [6:0] HALT_OPCODE = 7'h7F;
  localparam logic [6:0] PC_HOLD     = 7'h7F;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_t;

  function automatic logic is_halt_opcode(input logic [6:0] opcode);
    return (opcode == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one outstanding request at a time, a registered IF/ID output,
// and the advance/hold code that steers the program counter.
module instr_fetch_unit
  import rv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ILEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] current_ins_add,
  output logic [6:0]       pc_scr,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [ILEN-1:0]  imem_rsp_data,
  output logic             if_valid,
  output logic [ILEN-1:0]  if_instr,
  output logic [WIDTH-1:0] if_pc,
  input  logic             id_ready,
  output logic             halted
);

  fetch_state_t     state_r;
  fetch_state_t     next_s;
  logic [WIDTH-1:0] addr_r;
  logic [ILEN-1:0]  instr_r;
  logic [WIDTH-1:0] pc_r;
  logic             valid_r;
  logic             halted_r;

  logic             fire_s;
  logic             rsp_take_s;
  logic             rsp_halt_s;
  logic             accept_s;
  logic             req_valid_s;
  logic [6:0]       pc_scr_s;
  logic [WIDTH-1:0] addr_s;

  // Handshake qualifiers; responses outside WAIT are never looked at.
  always_comb begin
    req_valid_s = (state_r == REQ);
    fire_s      = req_valid_s && imem_req_ready;
    rsp_take_s  = (state_r == WAIT) && imem_rsp_valid;
    rsp_halt_s  = rsp_take_s && is_halt_opcode(imem_rsp_data[6:0]);
    accept_s    = (state_r == HOLD) && valid_r && id_ready;
  end

  // Next-state logic.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: next_s = REQ;
      REQ: begin
        if (fire_s) begin
          next_s = WAIT;
        end else begin
          next_s = REQ;
        end
      end
      WAIT: begin
        if (rsp_halt_s) begin
          next_s = HALT;
        end else if (rsp_take_s) begin
          next_s = HOLD;
        end else begin
          next_s = WAIT;
        end
      end
      HOLD: begin
        if (accept_s) begin
          next_s = REQ;
        end else begin
          next_s = HOLD;
        end
      end
      HALT:    next_s = HALT;
      default: next_s = IDLE;
    endcase
  end

  // PC only advances on the decode-accept cycle; the request address follows
  // the PC while in REQ (the PC is parked there) and is frozen afterwards.
  always_comb begin
    pc_scr_s = PC_HOLD;
    addr_s   = addr_r;
    if (accept_s) begin
      pc_scr_s = instr_r[6:0];
    end else begin
      pc_scr_s = PC_HOLD;
    end
    if (req_valid_s) begin
      addr_s = current_ins_add;
    end else begin
      addr_s = addr_r;
    end
  end

  // State register and IF/ID output register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= IDLE;
      addr_r   <= {WIDTH{1'b0}};
      instr_r  <= {ILEN{1'b0}};
      pc_r     <= {WIDTH{1'b0}};
      valid_r  <= 1'b0;
      halted_r <= 1'b0;
    end else begin
      state_r <= next_s;
      if (req_valid_s) begin
        addr_r <= current_ins_add;
      end
      if (rsp_halt_s) begin
        halted_r <= 1'b1;
      end else if (rsp_take_s) begin
        instr_r <= imem_rsp_data;
        pc_r    <= addr_r;
        valid_r <= 1'b1;
      end else if (accept_s) begin
        valid_r <= 1'b0;
      end
    end
  end

  assign pc_scr         = pc_scr_s;
  assign imem_req_valid = req_valid_s;
  assign imem_addr      = addr_s;
  assign if_valid       = valid_r;
  assign if_instr       = instr_r;
  assign if_pc          = pc_r;
  assign halted         = halted_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit with a program-counter model and a
// table-driven memory/decode responder.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [6:0]  pc_scr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        halted;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  bit stress  = 1'b1;

  exp_t exp_q[$];
  int   acc_q[$];

  logic [31:0] mem [0:15];
  int stall_for   [0:15];
  int idstall_for [0:15];
  bit spur_req    [0:15];
  bit spur_hold   [0:15];

  instr_fetch_unit #(.WIDTH(32), .ILEN(32)) dut (
    .clk(clk), .rst(rst), .current_ins_add(pc), .pc_scr(pc_scr),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_instr(if_instr),
    .if_pc(if_pc), .id_ready(id_ready), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) pc <= 32'd0;
    else if (pc_scr != 7'h7F) pc <= pc + 32'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory and decode responder: all inputs change at negedge.
  initial begin : responder
    int  cnt, stall, idstall;
    bit  req_seen, hold_seen, spur, fire;
    logic [31:0] pend;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 32'h00000013; stall_for[i] = 0; idstall_for[i] = 0;
      spur_req[i] = 1'b0; spur_hold[i] = 1'b0;
    end
    mem[3] = 32'h0000007F;
    stall_for[1] = 4; spur_req[1] = 1'b1; spur_req[2] = 1'b1;
    idstall_for[2] = 5; spur_hold[2] = 1'b1;
    cnt = 0; stall = 0; idstall = 0; req_seen = 0; hold_seen = 0; spur = 0; pend = 32'd0;
    imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'd0; id_ready = 1'b1;
    forever begin
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      if (!rst) begin
        cnt = 0; stall = 0; idstall = 0; req_seen = 0; hold_seen = 0; spur = 0;
        imem_req_ready = 1'b1; id_ready = 1'b1;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem[pend[3:0]];
          end
        end
        if (imem_req_valid && !req_seen) begin
          req_seen = 1'b1;
          if (stress) begin
            stall = stall_for[imem_addr[3:0]];
            spur  = spur_req[imem_addr[3:0]];
          end
        end
        if (stall > 0) begin imem_req_ready = 1'b0; stall--; end
        else imem_req_ready = 1'b1;
        fire = imem_req_valid && imem_req_ready;
        if (fire) begin req_seen = 1'b0; cnt = 1; pend = imem_addr; end
        if (if_valid && !hold_seen) begin
          hold_seen = 1'b1;
          if (stress) begin
            idstall = idstall_for[if_pc[3:0]];
            if (spur_hold[if_pc[3:0]]) spur = 1'b1;
          end
        end
        if (idstall > 0) begin id_ready = 1'b0; idstall--; end
        else id_ready = 1'b1;
        if (if_valid && id_ready) hold_seen = 1'b0;
        if (spur) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = 32'hDEADBEEF;
          spur = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every decode accept.
  initial begin : monitor
    bit   prev_valid, prev_acc, acc;
    logic [31:0] prev_instr, prev_pc;
    exp_t e;
    prev_valid = 0; prev_acc = 0; prev_instr = 32'd0; prev_pc = 32'd0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        prev_valid = 0; prev_acc = 0;
      end else begin
        acc = if_valid && id_ready;
        if (acc) begin
          if (exp_q.size() == 0) begin
            check("unexpected_if_valid", 64'(if_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_if_pc", 64'(if_pc), 64'(e.pc));
            check("sb_if_instr", 64'(if_instr), 64'(e.instr));
            check("sb_pc_scr", 64'(pc_scr), 64'(e.instr[6:0]));
            acc_q.push_back(cyc);
          end
        end else begin
          check("pc_scr_hold", 64'(pc_scr), 64'(7'h7F));
        end
        if (if_valid && prev_valid && !prev_acc) begin
          check("if_instr_stable", 64'(if_instr), 64'(prev_instr));
          check("if_pc_stable", 64'(if_pc), 64'(prev_pc));
        end
        prev_valid = if_valid; prev_acc = acc; prev_instr = if_instr; prev_pc = if_pc;
      end
    end
  end

  task automatic reset_checks();
    check("rst_pc_scr", 64'(pc_scr), 64'(7'h7F));
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_imem_addr", 64'(imem_addr), 64'd0);
    check("rst_if_valid", 64'(if_valid), 64'd0);
    check("rst_if_instr", 64'(if_instr), 64'd0);
    check("rst_if_pc", 64'(if_pc), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);
  endtask

  task automatic wait_req(input logic [31:0] a, output int n);
    bit found = 1'b0;
    n = 0;
    while (!found && n < 60) begin
      @(negedge clk); #1; n++;
      if (imem_req_valid && imem_addr == a) found = 1'b1;
    end
    check("req_timeout", 64'(found), 64'd1);
  endtask

  task automatic wait_hold(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); #1;
      if (if_valid && if_pc == a) found = 1'b1;
    end
    check("hold_timeout", 64'(found), 64'd1);
  endtask

  task automatic wait_halt();
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); #1;
      if (halted) found = 1'b1;
    end
    check("halt_timeout", 64'(found), 64'd1);
  endtask

  task automatic push_exp(input logic [31:0] a);
    exp_t e;
    e.pc = a; e.instr = 32'h00000013;
    exp_q.push_back(e);
  endtask

  initial begin : main
    int n;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    reset_checks();
    rst = 1'b1;
    push_exp(32'd0); push_exp(32'd1); push_exp(32'd2);
    wait_req(32'd0, n);
    check("first_req_cycle", 64'(n), 64'd1);

    // Memory not ready for 4 cycles on address 1.
    wait_req(32'd1, n);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      check("stall_req_valid", 64'(imem_req_valid), 64'd1);
      check("stall_imem_addr", 64'(imem_addr), 64'd1);
      check("stall_pc", 64'(pc), 64'd1);
    end

    // Decode not ready for 5 cycles on address 2.
    wait_hold(32'd2);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      check("idstall_pc_scr", 64'(pc_scr), 64'(7'h7F));
      check("idstall_pc", 64'(pc), 64'd2);
    end
    @(negedge clk); #1;
    check("idstall_release_pc_scr", 64'(pc_scr), 64'(7'h13));
    wait_req(32'd3, n);
    check("req_after_release", 64'(n), 64'd1);

    // Halt word at address 3.
    wait_halt();
    check("halt_if_valid", 64'(if_valid), 64'd0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      check("halt_pc_parked", 64'(pc), 64'd3);
      check("halt_sticky", 64'(halted), 64'd1);
      check("halt_no_req", 64'(imem_req_valid), 64'd0);
    end
    check("sb_drained_run1", 64'(exp_q.size()), 64'd0);

    // Reset out of HALT, then reset again in the middle of a WAIT.
    stress = 1'b0;
    rst = 1'b0;
    @(negedge clk); #1;
    reset_checks();
    rst = 1'b1;
    push_exp(32'd0); push_exp(32'd1);
    wait_req(32'd0, n);
    check("first_req_cycle_2", 64'(n), 64'd1);
    wait_req(32'd2, n);
    @(negedge clk); #1;
    check("in_wait_rsp_valid", 64'(imem_rsp_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk); #1;
    reset_checks();
    check("sb_drained_midwait", 64'(exp_q.size()), 64'd0);
    rst = 1'b1;
    acc_q.delete();
    push_exp(32'd0); push_exp(32'd1); push_exp(32'd2);
    wait_req(32'd0, n);
    check("restart_req_cycle", 64'(n), 64'd1);
    wait_req(32'd3, n);
    check("throughput_count", 64'(acc_q.size()), 64'd3);
    if (acc_q.size() == 3) begin
      check("throughput_gap_1", 64'(acc_q[1] - acc_q[0]), 64'd3);
      check("throughput_gap_2", 64'(acc_q[2] - acc_q[1]), 64'd3);
    end
    wait_halt();
    @(negedge clk); #1;
    check("halt2_pc_parked", 64'(pc), 64'd3);
    check("sb_drained_run2", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
